int_ctrl: RTL and testbench

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_if.sv | 29 ++
 rtl/int_ctrl.sv | 111 +++++++++++
 tb/tb_int_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_if.sv
// Bus bundle for int_ctrl: source/mask/enable inputs, ack/eoi handshake and the
// request/vector/pending/busy outputs. state_dbg mirrors the controller FSM.
interface int_ctrl_if #(
    parameter int NUM_SRC = 8
);
    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] mask_in;
    logic               gie_in;
    logic               ack_in;
    logic               eoi_in;
    logic               irq_out;
    logic [3:0]         vec_out;
    logic [NUM_SRC-1:0] pending_out;
    logic               busy_out;
    logic [1:0]         state_dbg;

    // Handshake: irq_out is held with a stable vec_out until ack_in is seen high at a
    // rising edge; ack_in is ignored when irq_out is low. After the ack, busy_out stays
    // high until eoi_in is seen high at a rising edge; eoi_in is ignored otherwise.
    modport master (
        output src_in, mask_in, gie_in, ack_in, eoi_in,
        input  irq_out, vec_out, pending_out, busy_out, state_dbg
    );

    modport slave (
        input  src_in, mask_in, gie_in, ack_in, eoi_in,
        output irq_out, vec_out, pending_out, busy_out, state_dbg
    );
endinterface

// File: rtl/int_ctrl.sv
// Prioritised interrupt controller: lowest enabled pending source wins, IDLE/REQ/SERVICE.
// Define INT_CTRL_EDGE_EN for rising-edge events; the default build treats a high level as an event.
module int_ctrl #(
    parameter int NUM_SRC = 8
) (
    input  logic         clk,
    input  logic         rst,
    int_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t             state_q;
    logic [NUM_SRC-1:0] samp_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_d;
    logic [3:0]         vec_q;
    logic               irq_q;
    logic               busy_q;

    logic [NUM_SRC-1:0] event_w;
    logic [NUM_SRC-1:0] enabled_w;
    logic [NUM_SRC-1:0] clr_w;
    logic [3:0]         first_idx;

`ifdef INT_CTRL_EDGE_EN
    logic [NUM_SRC-1:0] hist_q;
    assign event_w = samp_q & ~hist_q;
`else
    assign event_w = samp_q;
`endif

    assign enabled_w = pend_q & bus.mask_in;

    // Scan from the top down so the lowest set index is the final assignment.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (enabled_w[i]) first_idx = 4'(i);
        end
    end

    always_comb begin
        clr_w = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_w[i] = (state_q == REQ) && bus.ack_in && (vec_q == 4'(i));
        end
    end

    // A new event on the acknowledged source overrides its clear.
    assign pend_d = (pend_q & ~clr_w) | event_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            samp_q  <= '0;
            pend_q  <= '0;
            vec_q   <= '0;
            irq_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef INT_CTRL_EDGE_EN
            hist_q  <= '0;
`endif
        end else begin
            samp_q <= bus.src_in;
            pend_q <= pend_d;
`ifdef INT_CTRL_EDGE_EN
            hist_q <= samp_q;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.gie_in && (|enabled_w)) begin
                        state_q <= REQ;
                        vec_q   <= first_idx;
                        irq_q   <= 1'b1;
                    end
                end
                // Once presented, the request holds regardless of gie_in/mask_in.
                REQ: begin
                    if (bus.ack_in) begin
                        state_q <= SERVICE;
                        irq_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (bus.eoi_in) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    irq_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_out     = irq_q;
    assign bus.vec_out     = vec_q;
    assign bus.pending_out = pend_q;
    assign bus.busy_out    = busy_q;
    assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed table, corner-case sequences and randomized traffic
// checked against a cycle-level reference model.
module tb_int_ctrl;
  localparam int N = 8;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int_ctrl_if #(.NUM_SRC(N)) bus ();
  int_ctrl #(.NUM_SRC(N)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [N-1:0] m_samp, m_hist, m_pend;
  logic         m_req, m_svc;
  logic [3:0]   m_vec;
  logic [N-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic [N-1:0] src;
    logic [N-1:0] mask;
    logic         gie, ack, eoi;
    logic         irq;
    logic [3:0]   vec;
    logic [N-1:0] pend;
    logic         busy;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [N-1:0] src, input logic [N-1:0] mask,
                            input logic gie, input logic ack, input logic eoi, input logic r);
    logic [N-1:0] ev, nxt;
    if (r) begin
      m_samp = '0; m_hist = '0; m_pend = '0; m_req = 0; m_svc = 0; m_vec = '0;
      return;
    end
`ifdef INT_CTRL_EDGE_EN
    ev = m_samp & ~m_hist;
`else
    ev = m_samp;
`endif
    nxt = m_pend;
    if (m_req && ack) nxt[m_vec] = 1'b0;
    nxt = nxt | ev;
    if (m_req) begin
      if (ack) begin m_req = 0; m_svc = 1; end
    end else if (m_svc) begin
      if (eoi) m_svc = 0;
    end else if (gie && ((m_pend & mask) != '0)) begin
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && mask[i]) begin m_vec = 4'(i); break; end
      end
      m_req = 1;
    end
    m_pend = nxt;
    m_hist = m_samp;
    m_samp = src;
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1 after the rising edge
  task automatic cycle(input logic [N-1:0] src, input logic [N-1:0] mask,
                       input logic gie, input logic ack, input logic eoi, input logic r);
    @(negedge clk);
    rst = r;
    bus.src_in = src; bus.mask_in = mask; bus.gie_in = gie;
    bus.ack_in = ack; bus.eoi_in = eoi;
    @(posedge clk);
    model_edge(src, mask, gie, ack, eoi, r);
    exp_q.push_back(m_pend);
    #1;
  endtask

  task automatic check_model();
    logic [N-1:0] ep;
    ep = exp_q.pop_front();
    check("pending", 32'(bus.pending_out), 32'(ep));
    check("irq", 32'(bus.irq_out), 32'(m_req));
    check("busy", 32'(bus.busy_out), 32'(m_svc));
    check("vec", 32'(bus.vec_out), 32'(m_vec));
  endtask

  task automatic run(input logic [N-1:0] src, input logic [N-1:0] mask,
                     input logic gie, input logic ack, input logic eoi);
    cycle(src, mask, gie, ack, eoi, 1'b0);
    check_model();
  endtask

  initial begin
    rst = 1'b1;
    bus.src_in = '0; bus.mask_in = '0; bus.gie_in = 0; bus.ack_in = 0; bus.eoi_in = 0;
    m_samp = '0; m_hist = '0; m_pend = '0; m_req = 0; m_svc = 0; m_vec = '0;

    //           rst  src    mask   gie ack eoi  irq vec   pend   busy
    tbl[0] = '{1'b1, 8'hFF, 8'hFF, 1, 0, 0, 0, 4'd0, 8'h00, 0};
    tbl[1] = '{1'b1, 8'hFF, 8'hFF, 1, 0, 0, 0, 4'd0, 8'h00, 0};
    tbl[2] = '{1'b0, 8'h00, 8'hFF, 1, 0, 0, 0, 4'd0, 8'h00, 0};
    tbl[3] = '{1'b0, 8'h01, 8'hFF, 1, 0, 0, 0, 4'd0, 8'h00, 0};
    tbl[4] = '{1'b0, 8'h00, 8'hFF, 1, 0, 0, 0, 4'd0, 8'h01, 0};
    tbl[5] = '{1'b0, 8'h00, 8'hFF, 1, 0, 0, 1, 4'd0, 8'h01, 0};
    tbl[6] = '{1'b0, 8'h00, 8'hFF, 1, 1, 0, 0, 4'd0, 8'h00, 1};
    tbl[7] = '{1'b0, 8'h00, 8'hFF, 1, 0, 0, 0, 4'd0, 8'h00, 1};
    tbl[8] = '{1'b0, 8'h00, 8'hFF, 1, 0, 1, 0, 4'd0, 8'h00, 0};
    tbl[9] = '{1'b0, 8'h00, 8'hFF, 1, 0, 0, 0, 4'd0, 8'h00, 0};

    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].src, tbl[i].mask, tbl[i].gie, tbl[i].ack, tbl[i].eoi, tbl[i].rst);
      void'(exp_q.pop_front());
      check($sformatf("tbl%0d_irq", i), 32'(bus.irq_out), 32'(tbl[i].irq));
      check($sformatf("tbl%0d_vec", i), 32'(bus.vec_out), 32'(tbl[i].vec));
      check($sformatf("tbl%0d_pend", i), 32'(bus.pending_out), 32'(tbl[i].pend));
      check($sformatf("tbl%0d_busy", i), 32'(bus.busy_out), 32'(tbl[i].busy));
    end

    // priority: 3 before 5
    run(8'h28, 8'hFF, 1, 0, 0);
    run(8'h00, 8'hFF, 1, 0, 0);
    run(8'h00, 8'hFF, 1, 0, 0);
    check("prio_first_irq", 32'(bus.irq_out), 32'd1);
    check("prio_first_vec", 32'(bus.vec_out), 32'd3);
    run(8'h00, 8'hFF, 1, 1, 0);
    run(8'h00, 8'hFF, 1, 0, 1);
    run(8'h00, 8'hFF, 1, 0, 0);
    check("prio_second_vec", 32'(bus.vec_out), 32'd5);
    run(8'h00, 8'hFF, 1, 1, 0);
    run(8'h00, 8'hFF, 1, 0, 1);

    // masking and gie, then request held through gie/mask drop
    run(8'h04, 8'h00, 1, 0, 0);
    run(8'h00, 8'h00, 1, 0, 0);
    run(8'h00, 8'h00, 1, 0, 0);
    check("mask_pend2", 32'(bus.pending_out[2]), 32'd1);
    check("mask_irq", 32'(bus.irq_out), 32'd0);
    run(8'h00, 8'h04, 0, 0, 0);
    check("gie_irq", 32'(bus.irq_out), 32'd0);
    run(8'h00, 8'h04, 1, 0, 0);
    check("unmask_irq", 32'(bus.irq_out), 32'd1);
    check("unmask_vec", 32'(bus.vec_out), 32'd2);
    run(8'h00, 8'h00, 0, 0, 0);
    check("hold_irq", 32'(bus.irq_out), 32'd1);
    run(8'h00, 8'hFF, 1, 1, 0);
    run(8'h00, 8'hFF, 1, 0, 1);

    // collision: event on source 1 lands on the ack edge
    run(8'h02, 8'hFF, 1, 0, 0);
    run(8'h00, 8'hFF, 1, 0, 0);
    run(8'h00, 8'hFF, 1, 0, 0);
    check("coll_vec", 32'(bus.vec_out), 32'd1);
    run(8'h02, 8'hFF, 1, 0, 0);
    run(8'h00, 8'hFF, 1, 1, 0);
    check("coll_pend1", 32'(bus.pending_out[1]), 32'd1);
    check("coll_busy", 32'(bus.busy_out), 32'd1);
    run(8'h00, 8'hFF, 1, 0, 1);
    run(8'h00, 8'hFF, 1, 0, 0);
    check("coll_again_irq", 32'(bus.irq_out), 32'd1);
    check("coll_again_vec", 32'(bus.vec_out), 32'd1);
    run(8'h00, 8'hFF, 1, 1, 0);
    run(8'h00, 8'hFF, 1, 0, 1);

    // edge vs level: source 4 held high through a full service
    run(8'h10, 8'hFF, 1, 0, 0);
    run(8'h10, 8'hFF, 1, 0, 0);
    run(8'h10, 8'hFF, 1, 0, 0);
    check("hold4_vec", 32'(bus.vec_out), 32'd4);
    run(8'h10, 8'hFF, 1, 1, 0);
    run(8'h10, 8'hFF, 1, 0, 1);
    run(8'h10, 8'hFF, 1, 0, 0);
    run(8'h10, 8'hFF, 1, 0, 0);
`ifdef INT_CTRL_EDGE_EN
    check("edge_once_irq", 32'(bus.irq_out), 32'd0);
    check("edge_once_pend", 32'(bus.pending_out), 32'd0);
`else
    check("level_again_irq", 32'(bus.irq_out), 32'd1);
    check("level_again_vec", 32'(bus.vec_out), 32'd4);
`endif

    // randomized traffic with occasional asynchronous reset
    cycle('0, '0, 0, 0, 0, 1'b1);
    check_model();
    for (int i = 0; i < 800; i++) begin
      logic [N-1:0] s, m;
      s = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      cycle(s, m, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
      check_model();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
